response_queue: RTL

RESPONSE_QUEUE -- requirements
Module: response_queue

---
 rtl/response_queue_pkg.sv | 23 ++
 rtl/response_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/response_queue_pkg.sv
// Shared widths, slot record and flush-match helper for the response queue.
package response_queue_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ID_WIDTH   = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ID_WIDTH-1:0]   id_t;

  typedef struct packed {
    logic  live;
    id_t   id;
    data_t data;
  } slot_t;

  // True when id is named by either active flush request this cycle.
  function automatic logic flush_hit(input id_t id,
                                     input logic f1, input id_t fid1,
                                     input logic f2, input id_t fid2);
    return (f1 && (id == fid1)) || (f2 && (id == fid2));
  endfunction

endpackage

// File: rtl/response_queue.sv
// Circular response buffer with per-slot id flush, killed-head draining and
// a sticky overflow flag. Outputs come straight from the head slot registers.
module response_queue
  import response_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [ID_WIDTH-1:0]     in_id,
  input  logic                    in_valid,
  input  logic                    in_flush_1,
  input  logic [ID_WIDTH-1:0]     in_flush_id_1,
  input  logic                    in_flush_2,
  input  logic [ID_WIDTH-1:0]     in_flush_id_2,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic [$clog2(DEPTH):0]  out_count,
  output logic                    out_overflow
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic head_occ;
  logic head_live;
  logic head_kill;
  logic in_kill;
  logic pop;
  logic push;
  logic drop;

  // Head status, pop/push/drop decisions and head-slot outputs.
  always_comb begin
    head_occ  = (cnt_q != '0);
    head_live = slot_q[rd_q].live;
    head_kill = flush_hit(slot_q[rd_q].id, in_flush_1, in_flush_id_1,
                          in_flush_2, in_flush_id_2);
    in_kill   = flush_hit(in_id, in_flush_1, in_flush_id_1,
                          in_flush_2, in_flush_id_2);

    // A head being killed this cycle is held back from the consumer pop; it
    // drains as a dead entry on the following cycle instead.
    pop  = head_occ && (!head_live || (in_ready && !head_kill));
    push = in_valid && !in_kill && ((cnt_q != FULL_CNT) || pop);
    drop = in_valid && !in_kill && (cnt_q == FULL_CNT) && !pop;

    out_valid    = head_occ && head_live;
    out_data     = head_occ ? slot_q[rd_q].data : '0;
    out_id       = head_occ ? slot_q[rd_q].id   : '0;
    out_count    = cnt_q;
    out_overflow = ovf_q;
  end

  // Next-state: flush kills, pop retire, push write, pointer/count updates.
  always_comb begin
    slot_d = slot_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | drop;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush_hit(slot_q[i].id, in_flush_1, in_flush_id_1,
                    in_flush_2, in_flush_id_2)) begin
        slot_d[i].live = 1'b0;
      end
    end

    if (pop) begin
      slot_d[rd_q].live = 1'b0;
      rd_d              = rd_q + PTR_W'(1);
    end

    // When full with a simultaneous pop the write slot equals the retiring
    // head slot, so the push write is applied last to win.
    if (push) begin
      slot_d[wr_q] = '{live: 1'b1, id: in_id, data: in_data};
      wr_d         = wr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with asynchronous clear of everything, storage included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
